// File: rtl/dct_pkg.sv
// Shared constants and helpers for the DCT row pipeline stages.
package dct_pkg;

    localparam int DW_DEF  = 8;
    localparam int ROW_LEN = 8;
    localparam int ROWS    = 8;
    localparam int RIW     = 3;
    localparam int IDXW    = 3;

    typedef logic [RIW-1:0]  row_idx_t;
    typedef logic [IDXW-1:0] slot_idx_t;

    // Row counter increment that wraps at the block height.
    function automatic row_idx_t next_row(input row_idx_t r, input int rows);
        return (int'(r) == rows - 1) ? '0 : r + 1'b1;
    endfunction

endpackage

// File: rtl/row_buffer.sv
// One row of ROW_LEN bytes: single indexed write port, all bytes readable in parallel.
module row_buffer
    import dct_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  slot_idx_t                    idx,
    input  logic [DW-1:0]                din,
    output logic [ROW_LEN-1:0][DW-1:0]   dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (we) begin
            dout[idx] <= din;
        end
    end

endmodule

// File: rtl/row_collector.sv
// Byte-stream to 8-byte row packer with ping-pong row buffers, so one row can
// fill while the previous one waits for the downstream acknowledge.
module row_collector
    import dct_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ROWS = dct_pkg::ROWS
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          STBi,
    input  logic [DW-1:0] DATi,
    output logic          ACKi,
    output logic          STBo,
    output logic [DW-1:0] DATo0,
    output logic [DW-1:0] DATo1,
    output logic [DW-1:0] DATo2,
    output logic [DW-1:0] DATo3,
    output logic [DW-1:0] DATo4,
    output logic [DW-1:0] DATo5,
    output logic [DW-1:0] DATo6,
    output logic [DW-1:0] DATo7,
    output logic [2:0]    ROWo,
    input  logic          ACKo
);

    localparam row_idx_t ROW_MASK = RIW'(ROWS - 1);

    logic [1:0]      full;
    logic            wsel;
    logic            rsel;
    slot_idx_t       widx;
    row_idx_t        wrow;
    row_idx_t        rrow;

    logic            accept;
    logic            consume;
    logic            row_done;

    logic [1:0][ROW_LEN-1:0][DW-1:0] rows;
    logic [ROW_LEN-1:0][DW-1:0]      rd;

    // Handshakes depend only on registered state (plus reset).
    assign ACKi     = ~RST & ~full[wsel];
    assign STBo     = full[rsel];
    assign accept   = STBi & ACKi;
    assign consume  = STBo & ACKo;
    assign row_done = accept & (widx == slot_idx_t'(ROW_LEN - 1));

    for (genvar b = 0; b < 2; b++) begin : g_buf
        row_buffer #(.DW(DW)) u_row (
            .clk  (CLK),
            .rst  (RST),
            .we   (accept && (wsel == 1'(b))),
            .idx  (widx),
            .din  (DATi),
            .dout (rows[b])
        );
    end

    assign rd    = rows[rsel];
    assign DATo0 = rd[0];
    assign DATo1 = rd[1];
    assign DATo2 = rd[2];
    assign DATo3 = rd[3];
    assign DATo4 = rd[4];
    assign DATo5 = rd[5];
    assign DATo6 = rd[6];
    assign DATo7 = rd[7];
    assign ROWo  = rrow;

    // Completion and consume always touch different full bits: a row can only
    // complete into an empty buffer and only a full buffer can be consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full <= 2'b00;
            wsel <= 1'b0;
            rsel <= 1'b0;
            widx <= '0;
            wrow <= '0;
            rrow <= '0;
        end else begin
            if (accept) begin
                widx <= widx + 1'b1;
            end
            if (row_done) begin
                full[wsel] <= 1'b1;
                wsel       <= ~wsel;
                wrow       <= next_row(wrow, ROWS);
            end
            if (consume) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
                rrow       <= next_row(rrow, ROWS);
            end
        end
    end

    logic [RIW-1:0] pending;
    logic [RIW-1:0] full_cnt;

    assign pending  = (wrow - rrow) & ROW_MASK;
    assign full_cnt = {1'b0, full[0] & full[1], full[0] ^ full[1]};

    // Writer may only be blocked when both buffers are full; completed minus
    // consumed rows must match the number of occupied buffers.
    always @(posedge CLK) begin
        if (!RST) begin
            assert (!full[wsel] || (full[rsel] && (wsel == rsel)));
            assert (pending == full_cnt);
        end
    end

endmodule
